// File: rtl/hsfir_pkg.sv
// rtl/hsfir_pkg.sv - shared state encoding and counter sizing for the hsfir tap loader
package hsfir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hsfir_tap_loader.sv
// rtl/hsfir_tap_loader.sv - shifts coefficient sets into the FIR tap chain and reads them back by recirculation
module hsfir_tap_loader
  import hsfir_pkg::*;
#(
  parameter int NTAPS = 128,
  parameter int TW    = 12
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_start,
  input  logic          i_read_start,
  input  logic          i_coef_valid,
  output logic          o_coef_ready,
  input  logic [TW-1:0] i_coef,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  input  logic [TW-1:0] i_last_tap,
  output logic          o_rd_valid,
  input  logic          i_rd_ready,
  output logic [TW-1:0] o_rd_data,
  output logic          o_busy,
  output logic          o_done
);

  localparam int CW = cnt_width(NTAPS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NTAPS - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic w_in_load;
  logic w_in_read;
  logic w_load_hs;
  logic w_read_hs;

  // Gating with i_reset keeps the chain from shifting in the reset cycle itself.
  assign w_in_load = (r_state == ST_LOAD) && !i_reset;
  assign w_in_read = (r_state == ST_READ) && !i_reset;
  assign w_load_hs = w_in_load && i_coef_valid;
  assign w_read_hs = w_in_read && i_rd_ready;

  assign o_coef_ready = w_in_load;
  assign o_rd_valid   = w_in_read;
  assign o_rd_data    = w_in_read ? i_last_tap : '0;
  assign o_tap_wr     = w_load_hs || w_read_hs;
  assign o_tap        = w_load_hs ? i_coef : (w_read_hs ? i_last_tap : '0);
  assign o_busy       = (r_state != ST_IDLE) && !i_reset;
  assign o_done       = r_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (i_load_start) begin
            r_state <= ST_LOAD;
          end else if (i_read_start) begin
            r_state <= ST_READ;
          end
        end
        ST_LOAD: begin
          if (w_load_hs) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_BEAT) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_read_hs) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_BEAT) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/hsfir_tap_loader.md
# hsfir_tap_loader

Coefficient port controller for the high-speed FIR tap chain (adjustable-tap build, `FIXED_TAPS=0`). It writes a new coefficient set into the chain by shifting values in through the first tap's tap-write/tap-data inputs. It also reads the set back non-destructively by recirculating the last tap's coefficient output into the chain head. Both directions use valid/ready streams, so a bus bridge or a host-side FIFO can drive the block directly.

## Interface
Parameters:
- `NTAPS`, 128: number of taps in the attached chain; must be ≥ 2.
- `TW`, 12: coefficient width in bits. Must equal the chain's tap width.

Ports:
- `i_clk`  in  1: single clock, shared with the tap chain.
- `i_reset`  in  1: synchronous, active-high reset.
- `i_load_start`  in  1: request to load a new coefficient set. Sampled only in IDLE.
- `i_read_start`  in  1: request to read the coefficient set back. Sampled only in IDLE.
- `i_coef_valid`  in  1: load stream, data valid.
- `o_coef_ready`  out  1: load stream, ready.
- `i_coef`  in  TW: load stream, coefficient.
- `o_tap_wr`  out  1: drives the chain's tap-write input (shifts every tap one position).
- `o_tap`  out  TW: drives the first tap's coefficient input.
- `i_last_tap`  in  TW: coefficient output of the last tap in the chain.
- `o_rd_valid`  out  1: readback stream, data valid.
- `i_rd_ready`  in  1: readback stream, ready.
- `o_rd_data`  out  TW: readback stream, coefficient.
- `o_busy`  out  1: high while in LOAD or READ.
- `o_done`  out  1: one-cycle pulse when a load or a readback completes.

## Operation
- The FSM has three states: IDLE, LOAD and READ. A counter `cnt` of width clog2(NTAPS+1) tracks beats.
- IDLE:
  - `i_load_start` → LOAD with `cnt`=0.
  - Otherwise `i_read_start` → READ with `cnt`=0.
  - If both are high in the same cycle, LOAD wins and the read request is dropped.
- Start inputs are ignored outside IDLE. Requests are not queued.
- LOAD:
  - `o_coef_ready`=1, combinational from state.
  - `o_tap_wr` = `i_coef_valid` & `o_coef_ready`, and `o_tap` = `i_coef`.
  - Each handshake increments `cnt`.
  - On the handshake with `cnt`=NTAPS-1, the FSM returns to IDLE.
  - The first coefficient accepted ends up in the last tap.
- READ:
  - `o_rd_valid`=1 and `o_rd_data` = `i_last_tap`.
  - On each handshake (`o_rd_valid` & `i_rd_ready`): `o_tap_wr`=1, `o_tap` = `i_last_tap`, and `cnt` increments.
  - On the handshake with `cnt`=NTAPS-1, the FSM returns to IDLE.
  - Readback order equals load order. After NTAPS shifts the chain contents are restored exactly.
- When no handshake occurs, `o_tap_wr`=0 and the chain holds.
- `o_tap` = 0 whenever `o_tap_wr`=0, so the bus is deterministic.
- Coefficients pass bit-exact in both directions. There is no sign handling, saturation or rounding.
- Reset mid-operation:
  - The FSM returns to IDLE and `cnt`=0.
  - `o_tap_wr` is 0 in the reset cycle.
  - Chain contents are left partially shifted. The host must reload.
- The loader never drives the chain's data reset or data clock-enable.

## Timing
- Values during and after reset: `o_coef_ready`=0, `o_tap_wr`=0, `o_tap`=0, `o_rd_valid`=0, `o_rd_data`=0, `o_busy`=0, `o_done`=0.
- A start sampled at cycle t puts the FSM in LOAD or READ at t+1, where ready or valid is first high.
- Throughput is one coefficient per cycle. A full load or read takes a minimum of NTAPS cycles after entry.
- Last handshake at cycle t:
  - `o_done`=1 at t+1, and `o_busy`=0 at t+1.
  - A new start can be sampled at t+1.
- Tap registers update at the edge after `o_tap_wr`. In READ, `i_last_tap` therefore presents the next coefficient in the cycle after a handshake, so back-to-back reads are valid.
- `o_rd_data` is combinational from `i_last_tap`. It is registered in the chain, so there is no combinational loop.

## Structure
- A shared package `hsfir_pkg` holds:
  - the state encoding (IDLE=0, LOAD=1, READ=2);
  - the counter-width helper function used with NTAPS.
- Single module. No sub-module is warranted: the block is one FSM plus one counter.

## Test plan
Bench uses NTAPS=4 and TW=12, with a behavioural 4-stage tap shift-register model attached.
- Reset check: hold `i_reset` for 3 cycles → all outputs 0 and `o_busy`=0.
- Back-to-back load of 0x001, 0x002, 0x003, 0xFFF:
  - exactly 4 `o_tap_wr` pulses occur;
  - `o_done` pulses the cycle after the 4th beat;
  - model taps [0..3] = 0xFFF, 0x003, 0x002, 0x001.
- Load with `i_coef_valid` gaps (pattern 1,0,0,1,1,0,1) → only handshakes shift, and `o_done` follows the 4th accepted beat.
- Readback with `i_rd_ready` toggling 1,0,1,1,0,1:
  - `o_rd_data` sequence is 0x001, 0x002, 0x003, 0xFFF;
  - model taps are unchanged afterward;
  - `o_tap_wr` fires only on accepted beats.
- Start arbitration: `i_load_start` and `i_read_start` both high → LOAD entered. `i_read_start` pulsed during LOAD → ignored, with no READ after `o_done`.
- Reset after 2 load beats → IDLE next cycle with `o_tap_wr`=0. A following load accepts 4 fresh beats before `o_done`.
